// File: rtl/tdm_demux_if.sv
// Link-side bundle for the 1:4 TDM demultiplexer: one tagged word stream in,
// four held channel words, the last complete frame and status pulses out.
interface tdm_demux_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   din;
    logic               din_valid;
    logic               frame_sync;
    logic [4*WIDTH-1:0] Y;
    logic [3:0]         y_valid;
    logic [4*WIDTH-1:0] F;
    logic               frame_done;
    logic               sync_err;
    logic [1:0]         S;
    logic               locked;

    modport master (
        output din, din_valid, frame_sync,
        input  Y, y_valid, F, frame_done, sync_err, S, locked
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output Y, y_valid, F, frame_done, sync_err, S, locked
    );
endinterface

// File: rtl/tdm_demux_1_to_4.sv
// Receive-side 1:4 TDM demultiplexer: routes word k of each sync-marked frame to
// channel k, holds channel words, and publishes each complete frame atomically.
module tdm_demux_1_to_4 #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    tdm_demux_if.slave   bus
);
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   y_reg [4];
    logic [4*WIDTH-1:0] f_reg;
    logic [3:0]         y_valid_reg;
    logic               frame_done_reg;
    logic               sync_err_reg;
    logic [1:0]         s_reg;
    logic               locked_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= HUNT;
            for (int i = 0; i < 4; i++) y_reg[i] <= '0;
            f_reg          <= '0;
            y_valid_reg    <= 4'b0000;
            frame_done_reg <= 1'b0;
            sync_err_reg   <= 1'b0;
            s_reg          <= 2'd0;
            locked_reg     <= 1'b0;
        end else begin
            // Status outputs are single-cycle pulses; idle cycles leave everything else held.
            y_valid_reg    <= 4'b0000;
            frame_done_reg <= 1'b0;
            sync_err_reg   <= 1'b0;
            if (bus.din_valid) begin
                case (state_reg)
                    HUNT: begin
                        if (bus.frame_sync) begin
                            y_reg[0]    <= bus.din;
                            y_valid_reg <= 4'b0001;
                            s_reg       <= 2'd1;
                            state_reg   <= LOCKED;
                            locked_reg  <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (bus.frame_sync && s_reg != 2'd0) begin
                            // Early sync: abandon the partial frame and realign on this word.
                            sync_err_reg <= 1'b1;
                            y_reg[0]     <= bus.din;
                            y_valid_reg  <= 4'b0001;
                            s_reg        <= 2'd1;
                        end else if (!bus.frame_sync && s_reg == 2'd0) begin
                            sync_err_reg <= 1'b1;
                            state_reg    <= HUNT;
                            locked_reg   <= 1'b0;
                        end else begin
                            y_reg[s_reg] <= bus.din;
                            y_valid_reg  <= 4'b0001 << s_reg;
                            s_reg        <= s_reg + 2'd1;
                            // Slots 0..2 in y_reg were all written in this frame,
                            // otherwise S could not have reached 3 without a realign.
                            if (s_reg == 2'd3) begin
                                f_reg          <= {bus.din, y_reg[2], y_reg[1], y_reg[0]};
                                frame_done_reg <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_reg  <= HUNT;
                        locked_reg <= 1'b0;
                        s_reg      <= 2'd0;
                    end
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pack
            assign bus.Y[gi*WIDTH +: WIDTH] = y_reg[gi];
        end
    endgenerate

    assign bus.F          = f_reg;
    assign bus.y_valid    = y_valid_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.sync_err   = sync_err_reg;
    assign bus.S          = s_reg;
    assign bus.locked     = locked_reg;
endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
// Bench for tdm_demux_1_to_4: directed framing scenarios plus a randomized stream
// checked against a slot-counting reference model.
module tb_tdm_demux_1_to_4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tdm_demux_if #(.WIDTH(W)) bus ();

    tdm_demux_1_to_4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: a slot counter, channel store and frame snapshot.
    bit         m_locked;
    int         m_slot;
    logic [7:0] m_ch [4];
    logic [7:0] m_frame [4];
    logic [3:0] m_yv;
    logic       m_fd;
    logic       m_se;

    function automatic void model_step(input logic v, input logic s, input logic [7:0] d,
                                       input logic r);
        m_yv = 4'b0000;
        m_fd = 1'b0;
        m_se = 1'b0;
        if (r) begin
            m_locked = 0;
            m_slot = 0;
            for (int k = 0; k < 4; k++) begin
                m_ch[k] = 8'h00;
                m_frame[k] = 8'h00;
            end
        end else if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_ch[0] = d; m_yv = 4'b0001; m_slot = 1; m_locked = 1;
                end
            end else if (s && m_slot != 0) begin
                m_se = 1'b1; m_ch[0] = d; m_yv = 4'b0001; m_slot = 1;
            end else if (!s && m_slot == 0) begin
                m_se = 1'b1; m_locked = 0;
            end else begin
                m_ch[m_slot] = d;
                m_yv = 4'(1 << m_slot);
                if (m_slot == 3) begin
                    for (int k = 0; k < 4; k++) m_frame[k] = m_ch[k];
                    m_fd = 1'b1;
                end
                m_slot = (m_slot + 1) % 4;
            end
        end
    endfunction

    function automatic logic [31:0] exp_y();
        return {m_ch[3], m_ch[2], m_ch[1], m_ch[0]};
    endfunction

    function automatic logic [31:0] exp_f();
        return {m_frame[3], m_frame[2], m_frame[1], m_frame[0]};
    endfunction

    task automatic cycle(input logic v, input logic s, input logic [7:0] d, input logic r);
        bus.din_valid  = v;
        bus.frame_sync = s;
        bus.din        = d;
        reset          = r;
        @(posedge clk);
        model_step(v, s, d, r);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 8'hAA, 1'b1);
        cycle(1'b1, 1'b1, 8'h55, 1'b1);
        tests_run++;
        if (bus.Y !== 32'h0 || bus.F !== 32'h0 || bus.y_valid !== 4'b0 || bus.frame_done !== 1'b0
            || bus.sync_err !== 1'b0 || bus.S !== 2'd0 || bus.locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: Y=%h F=%h yv=%b fd=%b se=%b S=%0d lk=%b, required all zero",
                     bus.Y, bus.F, bus.y_valid, bus.frame_done, bus.sync_err, bus.S, bus.locked);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_basic_frame();
        logic [7:0] a [4];
        for (int k = 0; k < 4; k++) a[k] = 8'($urandom);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, k == 0, a[k], 1'b0);
            tests_run++;
            if (bus.y_valid !== 4'(1 << k) || bus.Y[k*8 +: 8] !== a[k] || bus.frame_done !== (k == 3)) begin
                tests_failed++;
                $display("FAIL basic_slot%0d: yv=%b Y=%h fd=%b, required yv=%b word=%h fd=%b",
                         k, bus.y_valid, bus.Y[k*8 +: 8], bus.frame_done, 4'(1 << k), a[k], k == 3);
            end
        end
        tests_run++;
        if (bus.F !== {a[3], a[2], a[1], a[0]} || bus.S !== 2'd0 || bus.locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_frame: F=%h S=%0d lk=%b, required F=%h S=0 lk=1",
                     bus.F, bus.S, bus.locked, {a[3], a[2], a[1], a[0]});
        end
    endtask

    task automatic test_hunt();
        cycle(1'b1, 1'b1, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, 8'h11, 1'b0);
        cycle(1'b1, 1'b0, 8'h22, 1'b0);
        tests_run++;
        if (bus.y_valid !== 4'b0 || bus.locked !== 1'b0 || bus.Y !== 32'h0 || bus.sync_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL hunt_drop: yv=%b lk=%b Y=%h se=%b, required 0,0,0,0",
                     bus.y_valid, bus.locked, bus.Y, bus.sync_err);
        end
        cycle(1'b1, 1'b1, 8'h33, 1'b0);
        tests_run++;
        if (bus.Y !== 32'h0000_0033 || bus.y_valid !== 4'b0001 || bus.locked !== 1'b1 || bus.S !== 2'd1) begin
            tests_failed++;
            $display("FAIL hunt_lock: Y=%h yv=%b lk=%b S=%0d, required Y=00000033 yv=0001 lk=1 S=1",
                     bus.Y, bus.y_valid, bus.locked, bus.S);
        end
    endtask

    task automatic test_early_sync();
        logic [31:0] f_before;
        logic [7:0]  b [4];
        for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
        cycle(1'b1, 1'b1, 8'hC0, 1'b0);
        cycle(1'b1, 1'b0, 8'hC1, 1'b0);
        f_before = exp_f();
        cycle(1'b1, 1'b1, b[0], 1'b0);
        tests_run++;
        if (bus.sync_err !== 1'b1 || bus.F !== f_before || bus.Y[7:0] !== b[0] || bus.S !== 2'd1
            || bus.y_valid !== 4'b0001 || bus.frame_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL early_sync: se=%b F=%h Y0=%h S=%0d yv=%b fd=%b, required 1 %h %h 1 0001 0",
                     bus.sync_err, bus.F, bus.Y[7:0], bus.S, bus.y_valid, bus.frame_done, f_before, b[0]);
        end
        for (int k = 1; k < 4; k++) cycle(1'b1, 1'b0, b[k], 1'b0);
        tests_run++;
        if (bus.F !== {b[3], b[2], b[1], b[0]} || bus.frame_done !== 1'b1 || bus.sync_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL early_refill: F=%h fd=%b se=%b, required F=%h fd=1 se=0",
                     bus.F, bus.frame_done, bus.sync_err, {b[3], b[2], b[1], b[0]});
        end
    endtask

    task automatic test_missing_sync();
        logic [31:0] y_before;
        y_before = exp_y();
        cycle(1'b1, 1'b0, 8'h5A, 1'b0);
        tests_run++;
        if (bus.sync_err !== 1'b1 || bus.locked !== 1'b0 || bus.Y !== y_before || bus.y_valid !== 4'b0
            || bus.S !== 2'd0) begin
            tests_failed++;
            $display("FAIL missing_sync: se=%b lk=%b Y=%h yv=%b S=%0d, required 1 0 %h 0000 0",
                     bus.sync_err, bus.locked, bus.Y, bus.y_valid, bus.S, y_before);
        end
        cycle(1'b1, 1'b1, 8'hA5, 1'b0);
        tests_run++;
        if (bus.locked !== 1'b1 || bus.Y[7:0] !== 8'hA5 || bus.sync_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL relock: lk=%b Y0=%h se=%b, required lk=1 Y0=a5 se=0",
                     bus.locked, bus.Y[7:0], bus.sync_err);
        end
    endtask

    task automatic test_toggle_valid();
        logic [7:0] a [4];
        for (int k = 0; k < 4; k++) a[k] = 8'($urandom);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, k == 0, a[k], 1'b0);
            tests_run++;
            if (bus.y_valid !== 4'(1 << k)) begin
                tests_failed++;
                $display("FAIL toggle_slot%0d: yv=%b, required %b", k, bus.y_valid, 4'(1 << k));
            end
            cycle(1'b0, 1'($urandom), 8'($urandom), 1'b0);
            tests_run++;
            if (bus.y_valid !== 4'b0 || bus.frame_done !== 1'b0 || bus.sync_err !== 1'b0
                || bus.S !== 2'((k + 1) % 4)) begin
                tests_failed++;
                $display("FAIL toggle_idle%0d: yv=%b fd=%b se=%b S=%0d, required 0 0 0 %0d",
                         k, bus.y_valid, bus.frame_done, bus.sync_err, bus.S, (k + 1) % 4);
            end
        end
        tests_run++;
        if (bus.F !== {a[3], a[2], a[1], a[0]} || bus.Y !== {a[3], a[2], a[1], a[0]}) begin
            tests_failed++;
            $display("FAIL toggle_frame: F=%h Y=%h, required %h", bus.F, bus.Y, {a[3], a[2], a[1], a[0]});
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] a [4];
        for (int k = 0; k < 4; k++) a[k] = 8'($urandom);
        for (int k = 0; k < 3; k++) cycle(1'b1, k == 0, 8'($urandom), 1'b0);
        cycle(1'b1, 1'b1, 8'hEE, 1'b1);
        tests_run++;
        if (bus.Y !== 32'h0 || bus.F !== 32'h0 || bus.locked !== 1'b0 || bus.S !== 2'd0
            || bus.y_valid !== 4'b0) begin
            tests_failed++;
            $display("FAIL midframe_reset: Y=%h F=%h lk=%b S=%0d yv=%b, required all zero",
                     bus.Y, bus.F, bus.locked, bus.S, bus.y_valid);
        end
        for (int k = 0; k < 4; k++) cycle(1'b1, k == 0, a[k], 1'b0);
        tests_run++;
        if (bus.F !== {a[3], a[2], a[1], a[0]} || bus.frame_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL midframe_refill: F=%h fd=%b, required F=%h fd=1",
                     bus.F, bus.frame_done, {a[3], a[2], a[1], a[0]});
        end
    endtask

    task automatic test_random();
        logic v, s, r;
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 4) == 0);
            cycle(v, s, 8'($urandom), r);
            tests_run++;
            if (bus.Y !== exp_y() || bus.F !== exp_f() || bus.y_valid !== m_yv || bus.frame_done !== m_fd
                || bus.sync_err !== m_se || bus.S !== 2'(m_slot) || bus.locked !== m_locked
                || $countones(bus.y_valid) > 1 || (bus.frame_done && bus.sync_err)) begin
                tests_failed++;
                $display("FAIL random_%0d: Y=%h F=%h yv=%b fd=%b se=%b S=%0d lk=%b, required Y=%h F=%h yv=%b fd=%b se=%b S=%0d lk=%b",
                         n, bus.Y, bus.F, bus.y_valid, bus.frame_done, bus.sync_err, bus.S, bus.locked,
                         exp_y(), exp_f(), m_yv, m_fd, m_se, m_slot, m_locked);
            end
        end
    endtask

    initial begin
        bus.din = '0;
        bus.din_valid = 1'b0;
        bus.frame_sync = 1'b0;
        test_reset();
        test_basic_frame();
        test_hunt();
        test_early_sync();
        test_missing_sync();
        test_toggle_valid();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
